// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin shared seconds countdown for two requesters with prescaled tick.
// Optional `TIMER_SCHED_PAUSE_EN adds a pause input that freezes the countdown in RUN.
module timer_scheduler #(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W = 4
) (
  input  logic             clk100mhz,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] dur0,
  input  logic [CNT_W-1:0] dur1,
`ifdef TIMER_SCHED_PAUSE_EN
  input  logic             pause,
`endif
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy,
  output logic [CNT_W-1:0] remain,
  output logic             sec_tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [PW-1:0] presc, nxt_presc;
  logic [CNT_W-1:0] nd;
  logic [1:0] gv;
  logic last, win, own_req, wrap, hold;
`ifdef TIMER_SCHED_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  // Contested requests go to the port that was not granted last.
  assign win = (req[0] & req[1]) ? ~last : req[1];
  assign gv = win ? 2'b10 : 2'b01;
  assign nd = win ? dur1 : dur0;
  assign own_req = |(req & grant);
  assign wrap = presc == LAST;
  assign nxt_presc = wrap ? '0 : presc + 1'b1;
  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      done <= 2'b00;
      busy <= 1'b0;
      remain <= '0;
      sec_tick <= 1'b0;
      presc <= '0;
      last <= 1'b1;
    end else begin
      done <= 2'b00;
      sec_tick <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          grant <= gv;
          busy <= 1'b1;
          last <= win;
          remain <= nd;
          presc <= '0;
          state <= nd == '0 ? DONE : RUN;
          done <= nd == '0 ? gv : 2'b00;
          sec_tick <= nd != '0 && TICK_DIV == 1;
        end
        RUN: if (!own_req) begin
          state <= IDLE;
          grant <= 2'b00;
          busy <= 1'b0;
          remain <= '0;
          presc <= '0;
        end else if (!hold) begin
          presc <= nxt_presc;
          if (wrap) remain <= remain - CNT_W'(remain != '0);
          if (wrap && remain <= CNT_W'(1)) begin
            state <= DONE;
            done <= grant;
          end else begin
            // sec_tick is high during the cycle whose closing edge wraps the prescaler.
            sec_tick <= nxt_presc == LAST;
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= 2'b00;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
